instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the main control/ALU decode path. Accepts instruction descriptors (operation class plus register, immediate and target fields) over a valid/ready stream.
- Encodes each descriptor into a 32-bit MIPS word and buffers it in a small FIFO.
- Drains the FIFO into instruction memory through a sequential write port.
- Used by the test/boot infrastructure to load programs into the single-cycle core's instruction memory.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ADDR_W, 8, instruction-memory word-address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session at base_addr
- base_addr  in  ADDR_W  first word address of the session
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_last  in  1  qualifies the final descriptor of the session
- in_op  in  4  class: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate (I-type)
- in_target  in  26  jump target (J-type)
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- word_count  out  ADDR_W+1  words written this session
- err_illegal  out  1  sticky; an illegal in_op was accepted
- err_overflow  out  1  sticky; a write was attempted past address 2^ADDR_W-1

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0; mem_addr 0.
- Encoding, R-type (add/sub/and/or/slt): {6'b000000, rs, rt, rd, 5'b0, funct}. funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Encoding, I-type: {opcode, rs, rt, imm}. Opcodes: lw 100011, sw 101011, beq 000100, addi 001000.
- Encoding, J-type: {000010, target}.
- Unused fields are ignored.
- Illegal in_op: the descriptor is accepted and discarded (nothing is pushed), and err_illegal is set.
- FSM transitions:
  - IDLE --start--> LOAD. On that edge: mem_addr = base_addr, word_count = 0, error flags cleared.
  - LOAD --handshake with in_last--> DRAIN.
  - DRAIN --FIFO empty and no write this cycle--> DONE.
  - DONE --> IDLE unconditionally; done = 1 only while in DONE.
- start outside IDLE is ignored.
- in_ready = (state == LOAD) && !fifo_full. It does not depend on a same-cycle pop.
- A push occurs on the handshake edge. The word appears at the FIFO head and mem_we is asserted no earlier than the next cycle (1-cycle minimum latency).
- Pop/write occurs in LOAD or DRAIN whenever the FIFO is non-empty: mem_we = 1, mem_wdata = head, mem_addr = current address. One write per cycle.
- On each write, mem_addr increments by 1 and word_count increments by 1.
- Simultaneous push and pop in the same cycle are both performed; the occupancy count is unchanged.
- Overflow: the write to address 2^ADDR_W-1 completes and sets an internal wrap flag. Any later pop in the session is discarded with mem_we = 0, sets err_overflow, and does not increment word_count. Draining continues normally.
- An illegal descriptor carrying in_last still moves the FSM to DRAIN.
- Asynchronous reset mid-session aborts immediately: FIFO flushed, no done pulse.
- Outputs are registered: mem_we, mem_addr and mem_wdata change only on clk edges.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- When defined: adds output checksum [31:0]. It is cleared at start and XOR-accumulates every word actually written (mem_we = 1). It is valid and stable from the done pulse until the next start.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- start, base_addr = 0x10; add rs=1 rt=2 rd=3 with in_last -> one write: mem_addr 0x10, mem_wdata 0x00221820; done 3 cycles after the handshake; word_count 1.
- Back-to-back stream: lw rs=29 rt=8 imm=4; beq rs=1 rt=2 imm=0xFFFF; j target=0x10 (last) -> writes 0x8FA80004, 0x1022FFFF, 0x08000010 at consecutive addresses; no bubbles while in_valid is held.
- Hold off draining by sending 6 descriptors with DEPTH = 4 and in_valid continuous -> no descriptor lost; in_ready never high while full; 6 writes in order.
- in_op = 12 mid-stream between two adds -> err_illegal = 1; only 2 writes; word_count 2.
- base_addr = 0xFE with 3 words -> writes at 0xFE and 0xFF; third word dropped with mem_we = 0; err_overflow = 1; word_count 2; done still pulses.
- rst_n low during DRAIN -> all outputs 0 asynchronously; no done pulse; a following start runs cleanly. With ENC_CHECKSUM_EN defined, words 0x00221820 and 0x8FA80004 -> checksum 0x8F8A1824.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Turns instruction descriptors into 32-bit MIPS words, queues them in a small
// FIFO and streams them into instruction memory from a per-session base
// address. The single write is issued from registered outputs. A word is
// counted when its write cycle completes.
// Optional build macro ENC_CHECKSUM_EN adds a 32-bit XOR checksum output
// covering every word actually written in the session.
module instr_encoder_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_overflow
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]     CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]     CNT_FULL  = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Classes 0..9 are defined; 10..15 are rejected.
  function automatic logic op_is_legal(input logic [3:0] op);
    op_is_legal = (op <= 4'd9);
  endfunction

  // Build the MIPS word for one descriptor; fields a class does not use are ignored.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (op)
      4'd0:    encode_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    encode_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    encode_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    encode_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    encode_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    encode_word = {6'b100011, rs, rt, imm};
      4'd6:    encode_word = {6'b101011, rs, rt, imm};
      4'd7:    encode_word = {6'b000100, rs, rt, imm};
      4'd8:    encode_word = {6'b001000, rs, rt, imm};
      4'd9:    encode_word = {6'b000010, target};
      default: encode_word = 32'h0000_0000;
    endcase
  endfunction

  state_t            state_r;
  state_t            state_next_s;

  logic [31:0]       fifo_mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [ADDR_W:0]   word_count_r;
  logic              err_illegal_r;
  logic              err_overflow_r;
  logic              wrap_r;

  logic              start_s;
  logic              in_ready_s;
  logic              handshake_s;
  logic              legal_s;
  logic              push_s;
  logic              pop_s;
  logic              at_top_s;
  logic              wrap_now_s;
  logic              write_s;
  logic              drop_s;
  logic [31:0]       enc_word_s;
  logic [31:0]       head_s;

  assign start_s     = (state_r == ST_IDLE) && start;
  assign in_ready_s  = (state_r == ST_LOAD) && (count_r != CNT_FULL);
  assign handshake_s = in_valid && in_ready_s;
  assign legal_s     = op_is_legal(in_op);
  assign enc_word_s  = encode_word(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
  assign push_s      = handshake_s && legal_s;
  assign pop_s       = ((state_r == ST_LOAD) || (state_r == ST_DRAIN)) && (count_r != CNT_ZERO);
  assign head_s      = fifo_mem_r[rd_ptr_r];
  // The write to the top address may be completing on the same edge as this pop.
  assign at_top_s    = (mem_addr_r == ADDR_MAX);
  assign wrap_now_s  = wrap_r || (mem_we_r && at_top_s);
  assign write_s     = pop_s && !wrap_now_s;
  assign drop_s      = pop_s && wrap_now_s;

  assign in_ready     = in_ready_s;
  assign busy         = (state_r != ST_IDLE);
  assign done         = (state_r == ST_DONE);
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign word_count   = word_count_r;
  assign err_illegal  = err_illegal_r;
  assign err_overflow = err_overflow_r;

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; DRAIN ends only once the FIFO is empty and the last write has retired.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (handshake_s && in_last) state_next_s = ST_DRAIN;
        else                        state_next_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if ((count_r == CNT_ZERO) && !mem_we_r) state_next_s = ST_DONE;
        else                                    state_next_s = ST_DRAIN;
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Encoded-word FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= enc_word_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Write port, address/word tracking and sticky session errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r       <= 1'b0;
      mem_addr_r     <= {ADDR_W{1'b0}};
      mem_wdata_r    <= 32'h0000_0000;
      word_count_r   <= {(ADDR_W + 1){1'b0}};
      err_illegal_r  <= 1'b0;
      err_overflow_r <= 1'b0;
      wrap_r         <= 1'b0;
    end else if (start_s) begin
      mem_we_r       <= 1'b0;
      mem_addr_r     <= base_addr;
      word_count_r   <= {(ADDR_W + 1){1'b0}};
      err_illegal_r  <= 1'b0;
      err_overflow_r <= 1'b0;
      wrap_r         <= 1'b0;
    end else begin
      mem_we_r <= write_s;
      if (write_s) begin
        mem_wdata_r <= head_s;
      end
      // A write retires at the end of its mem_we cycle; the top address latches the wrap flag.
      if (mem_we_r) begin
        word_count_r <= word_count_r + WCNT_ONE;
        if (at_top_s) begin
          wrap_r <= 1'b1;
        end else begin
          mem_addr_r <= mem_addr_r + ADDR_ONE;
        end
      end
      if (drop_s) begin
        err_overflow_r <= 1'b1;
      end
      if (handshake_s && !legal_s) begin
        err_illegal_r <= 1'b1;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum_r;

  // XOR of every word that actually reached memory this session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= 32'h0000_0000;
    end else if (start_s) begin
      checksum_r <= 32'h0000_0000;
    end else if (mem_we_r) begin
      checksum_r <= checksum_r ^ mem_wdata_r;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed sessions from the
// test plan plus randomized sessions, all checked against a word-list model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done;
  logic [8:0]  word_count;
  logic        err_illegal, err_overflow;
`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .word_count(word_count),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [7:0] addr; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  int          m_base, m_legal, m_count;
  logic        m_ill, m_ovf;
  logic [31:0] m_sum;
  int          wr_n, wr_first, wr_last;
  int          cyc = 0;

  // MIPS word from field arithmetic: opcode<<26 | rs<<21 | rt<<16 | low part.
  function automatic logic [31:0] model_word(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [15:0] imm,
                                             input logic [25:0] tgt);
    int funct_tab [5];
    int opc_tab [4];
    funct_tab = '{32, 34, 36, 37, 42};
    opc_tab   = '{35, 43, 4, 8};
    if (op < 5)
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct_tab[op]);
    else if (op < 9)
      return (32'(opc_tab[op - 5]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else
      return (32'd2 << 26) | 32'(tgt);
  endfunction

  task automatic model_start(input int b);
    m_base = b; m_legal = 0; m_count = 0; m_ill = 1'b0; m_ovf = 1'b0; m_sum = 32'h0;
    exp_q.delete(); got_q.delete(); wr_n = 0; wr_first = 0; wr_last = 0;
  endtask

  task automatic model_accept(input int op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    exp_t e;
    if (op > 9) begin
      m_ill = 1'b1;
    end else begin
      w = model_word(op, rs, rt, rd, imm, tgt);
      if (m_base + m_legal <= 255) begin
        e.addr = 8'(m_base + m_legal);
        e.data = w;
        exp_q.push_back(e);
        m_count++;
        m_sum = m_sum ^ w;
      end else begin
        m_ovf = 1'b1;
      end
      m_legal++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every write the DUT issues must be the next one the model predicts.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {63'd0, mem_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {56'd0, mem_addr}, {56'd0, e.addr});
        check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
      end
      got_q.push_back(mem_wdata);
      if (wr_n == 0) wr_first = cyc;
      wr_last = cyc;
      wr_n++;
    end
  end

  // ---------------- stimulus tasks (all begin and end on a posedge) ----------------
  task automatic start_session(input int b);
    #1;
    start = 1'b1; base_addr = 8'(b); in_valid = 1'b0;
    @(posedge clk);
    model_start(b);
  endtask

  task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input int gap, input logic noise_start);
    logic rdy;
    int   guard;
    #1;
    start = 1'b0; in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_op = 4'(op); in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_last = last; in_valid = 1'b1;
    start = noise_start; base_addr = 8'($urandom_range(0, 255));
    guard = 0;
    rdy = 1'b0;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      guard++;
    end
    if (!rdy) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    else model_accept(op, rs, rt, rd, imm, tgt);
  endtask

  task automatic finish_session(output int lat);
    lat = 0;
    #1;
    in_valid = 1'b0; start = 1'b0; in_last = 1'b0;
    for (int k = 1; k <= 64 && lat == 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    if (lat == 0) begin
      check("done_timeout", {63'd0, done}, 64'd1);
    end else begin
      check("leftover_writes", 64'(exp_q.size()), 64'd0);
      check("word_count", {55'd0, word_count}, 64'(m_count));
      check("err_illegal", {63'd0, err_illegal}, {63'd0, m_ill});
      check("err_overflow", {63'd0, err_overflow}, {63'd0, m_ovf});
`ifdef ENC_CHECKSUM_EN
      check("checksum", {32'd0, checksum}, {32'd0, m_sum});
`endif
      @(negedge clk);
      check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    end
    @(posedge clk);
  endtask

  function automatic logic [63:0] out_vec();
    return {9'd0, mem_we, mem_addr, mem_wdata, busy, done, word_count, err_illegal, err_overflow, in_ready};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int n, b, op, gap;
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_op = 4'h0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0; in_target = 26'h0;
    model_start(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // T1: single add
    start_session(8'h10);
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 0, 1'b0);
    finish_session(lat);
    check("t1_done_latency", 64'(lat), 64'd4);
    check("t1_nwrites", 64'(wr_n), 64'd1);
    if (got_q.size() > 0) check("t1_word", {32'd0, got_q[0]}, 64'h0000_0000_0022_1820);
    check("t1_word_count_hold", {55'd0, word_count}, 64'd1);

    // T2: back-to-back lw / beq / j
    start_session(8'h20);
    send(5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 0, 1'b0);
    send(7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 0, 1'b0);
    send(9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 0, 1'b0);
    finish_session(lat);
    check("t2_nwrites", 64'(wr_n), 64'd3);
    if (got_q.size() == 3) begin
      check("t2_w0", {32'd0, got_q[0]}, 64'h0000_0000_8FA8_0004);
      check("t2_w1", {32'd0, got_q[1]}, 64'h0000_0000_1022_FFFF);
      check("t2_w2", {32'd0, got_q[2]}, 64'h0000_0000_0800_0010);
    end
    check("t2_no_bubbles", 64'(wr_last - wr_first), 64'd2);

    // T3: six descriptors through a 4-deep FIFO
    start_session(8'h40);
    for (int i = 0; i < 6; i++)
      send(i % 5, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 26'h0, (i == 5), 0, 1'b0);
    finish_session(lat);
    check("t3_nwrites", 64'(wr_n), 64'd6);
    check("t3_no_bubbles", 64'(wr_last - wr_first), 64'd5);

    // T4: illegal op between two adds
    start_session(8'h30);
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 0, 1'b0);
    send(12, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 0, 1'b0);
    send(0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 0, 1'b0);
    finish_session(lat);
    check("t4_err_illegal", {63'd0, err_illegal}, 64'd1);
    check("t4_word_count", {55'd0, word_count}, 64'd2);

    // T5: address overflow at the top of memory
    start_session(8'hFE);
    for (int i = 0; i < 3; i++)
      send(0, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, (i == 2), 0, 1'b0);
    finish_session(lat);
    check("t5_err_overflow", {63'd0, err_overflow}, 64'd1);
    check("t5_word_count", {55'd0, word_count}, 64'd2);
    check("t5_nwrites", 64'(wr_n), 64'd2);

    // T6: reset during DRAIN, then a clean session
    start_session(8'h50);
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 0, 1'b0);
    send(5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 0, 1'b0);
    #2;
    in_valid = 1'b0; start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", out_vec(), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_done", {62'd0, done, busy}, 64'd0);
    end
    @(posedge clk);
    start_session(8'h60);
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 0, 1'b0);
    send(5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 0, 1'b0);
    finish_session(lat);
    check("t6_clean_count", {55'd0, word_count}, 64'd2);
`ifdef ENC_CHECKSUM_EN
    check("t6_checksum", {32'd0, checksum}, 64'h0000_0000_8F8A_1824);
`endif

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      n = $urandom_range(1, 8);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(248, 255) : $urandom_range(0, 255);
      start_session(b);
      for (int i = 0; i < n; i++) begin
        op  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
             (i == n - 1), gap, ($urandom_range(0, 7) == 0));
      end
      finish_session(lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
